// File: rtl/accum_seg7_stage_pkg.sv
// Shared definitions for the accumulator / seven-segment display stage.
// Holds the op encoding, the control FSM state enum, the registered command
// record layout and the hex-to-segment table used by hex_seg7_decoder.
package accum_seg7_stage_pkg;

    // Op field encoding on io_in[7:6]
    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpAdd   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWaitRel
    } state_e;

    // Field order matches the pad layout io_in[7:2] = {op, data}
    typedef struct packed {
        logic [1:0] op;
        logic [3:0] data;
    } cmd_t;

    // Segment patterns, bit0=a .. bit6=g, active-high
    localparam logic [6:0] SegTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/accum_seg7_stage_if.sv
// Pad bus of the display stage: 8 inputs and 8 outputs.
//   io_in[0] clk, io_in[1] rst, io_in[5:2] data, io_in[7:6] op
//   io_out[6:0] segments a..g, io_out[7] overflow indicator
// master drives the inputs (board / bench), slave is the stage itself.
interface accum_seg7_stage_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (
        output io_in,
        input  io_out
    );

    modport slave (
        input  io_in,
        output io_out
    );
endinterface

// File: rtl/hex_seg7_decoder.sv
// Combinational hex digit to seven-segment decoder.
//   hex_i  4-bit digit
//   seg_o  segment pattern, bit0=a .. bit6=g, active-high
module hex_seg7_decoder
    import accum_seg7_stage_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SegTable[hex_i];
    end

endmodule

// File: rtl/accum_seg7_stage.sv
// 4-bit accumulator with seven-segment readout and blinking overflow lamp.
// Ports (all through the pad interface, slave side):
//   io_in[0] clk, io_in[1] rst (synchronous, active-high)
//   io_in[5:2] data nibble, io_in[7:6] op (NOP/LOAD/ADD/CLEAR)
//   io_out[6:0] digit of the accumulator, io_out[7] blinking overflow flag
// Each op assertion runs exactly once: the op must return to NOP before a
// new command is accepted.
module accum_seg7_stage
    import accum_seg7_stage_pkg::*;
#(
    parameter int unsigned BLINK_BITS = 3
) (
    accum_seg7_stage_if.slave pad_io
);

    logic clk;
    logic rst;

    assign clk = pad_io.io_in[0];
    assign rst = pad_io.io_in[1];

    state_e                state_q, state_d;
    cmd_t                  in_q, in_d;
    cmd_t                  cmd_q, cmd_d;
    logic [3:0]            acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;

    logic [4:0]            sum;
    logic [6:0]            seg;

    // The single adder; bit 4 is the carry-out
    assign sum = {1'b0, acc_q} + {1'b0, cmd_q.data};

    always_comb begin
        in_d    = pad_io.io_in[7:2];
        state_d = state_q;
        cmd_d   = cmd_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (in_q.op != OpNop) begin
                    state_d = StExec;
                    cmd_d   = in_q;
                end
            end
            StExec: begin
                state_d = StWaitRel;
                case (cmd_q.op)
                    OpLoad: begin
                        acc_d = cmd_q.data;
                        ovf_d = 1'b0;
                    end
                    OpAdd: begin
                        acc_d = sum[3:0];
                        ovf_d = ovf_q | sum[4];
                    end
                    OpClear: begin
                        acc_d = 4'h0;
                        ovf_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            StWaitRel: begin
                // Any non-NOP value, even a different op, keeps us here
                if (in_q.op == OpNop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Held at zero while clear, so it restarts from zero when ovf rises
        if (ovf_q) begin
            blink_d = blink_q + 1'b1;
        end else begin
            blink_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            in_q    <= '0;
            cmd_q   <= '0;
            acc_q   <= 4'h0;
            ovf_q   <= 1'b0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            cmd_q   <= cmd_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            blink_q <= blink_d;
        end
    end

    hex_seg7_decoder u_dec (
        .hex_i (acc_q),
        .seg_o (seg)
    );

    assign pad_io.io_out = {ovf_q & ~blink_q[BLINK_BITS-1], seg};

endmodule

// File: tb/tb_accum_seg7_stage.sv
module tb_accum_seg7_stage;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [1:0] op   = 2'b00;
    logic [3:0] data = 4'h0;

    accum_seg7_stage_if bus ();
    assign bus.io_in = {op, data, rst, clk};

    accum_seg7_stage #(
        .BLINK_BITS (3)
    ) dut (
        .pad_io (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] op;
        logic [3:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [6:0] seg_ref [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic void add(string n, logic r, logic [1:0] o, logic [3:0] d, logic [7:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command pulse; returns io_out right after the applying edge
    task automatic do_cmd(input logic [1:0] o, input logic [3:0] d, output logic [7:0] at_apply);
        op = o; data = d;
        tick();
        op = 2'b00;
        tick();
        tick();
        at_apply = bus.io_out;
        tick();
    endtask

    initial begin
        logic [7:0] r;
        logic       seen_hi, seen_lo;

        // Reset, idle, LOAD 5, ADD 3
        add("rst0", 1, 0, 0, 8'h3F);   add("rst1", 1, 0, 0, 8'h3F);
        add("idle0", 0, 0, 0, 8'h3F);  add("idle1", 0, 0, 0, 8'h3F);
        add("ld5_cap", 0, 1, 5, 8'h3F); add("ld5_exec", 0, 0, 0, 8'h3F);
        add("ld5_apply", 0, 0, 0, 8'h6D); add("ld5_hold", 0, 0, 0, 8'h6D);
        add("add3_cap", 0, 2, 3, 8'h6D); add("add3_exec", 0, 0, 0, 8'h6D);
        add("add3_apply", 0, 0, 0, 8'h7F); add("add3_hold", 0, 0, 0, 8'h7F);
        // LOAD F, ADD 1 wraps to 0 with overflow; lamp 4 on / 4 off
        add("ldF_cap", 0, 1, 15, 8'h7F); add("ldF_exec", 0, 0, 0, 8'h7F);
        add("ldF_apply", 0, 0, 0, 8'h71); add("ldF_hold", 0, 0, 0, 8'h71);
        add("add1_cap", 0, 2, 1, 8'h71); add("add1_exec", 0, 0, 0, 8'h71);
        add("wrap_on0", 0, 0, 0, 8'hBF); add("wrap_on1", 0, 0, 0, 8'hBF);
        add("wrap_on2", 0, 0, 0, 8'hBF); add("wrap_on3", 0, 0, 0, 8'hBF);
        add("wrap_off0", 0, 0, 0, 8'h3F); add("wrap_off1", 0, 0, 0, 8'h3F);
        add("wrap_off2", 0, 0, 0, 8'h3F); add("wrap_off3", 0, 0, 0, 8'h3F);
        add("clr_cap", 0, 3, 0, 8'hBF); add("clr_exec", 0, 0, 0, 8'hBF);
        add("clr_apply", 0, 0, 0, 8'h3F); add("clr_hold0", 0, 0, 0, 8'h3F);
        add("clr_hold1", 0, 0, 0, 8'h3F); add("clr_hold2", 0, 0, 0, 8'h3F);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; op = vecs[i].op; data = vecs[i].data;
            tick();
            check(vecs[i].name, bus.io_out, vecs[i].exp);
        end

        // ADD 2 held for 20 cycles executes once
        op = 2'b10; data = 4'h2;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("hold_add2_%0d", i), bus.io_out, (i < 2) ? 8'h3F : 8'h5B);
        end
        op = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_rel_%0d", i), bus.io_out, 8'h5B);
        end

        // Reset at the EXEC edge cancels ADD 4; held op reruns via IDLE
        op = 2'b10; data = 4'h4;
        tick(); check("rstx_cap", bus.io_out, 8'h5B);
        tick(); check("rstx_exec", bus.io_out, 8'h5B);
        rst = 1'b1;
        tick(); check("rstx_reset", bus.io_out, 8'h3F);
        rst = 1'b0;
        tick(); check("rstx_rel0", bus.io_out, 8'h3F);
        tick(); check("rstx_rel1", bus.io_out, 8'h3F);
        tick(); check("rstx_reexec", bus.io_out, 8'h66);
        tick(); check("rstx_hold", bus.io_out, 8'h66);
        op = 2'b00;
        tick(); tick(); tick();

        // ADD 1 then op switched straight to CLEAR: CLEAR ignored
        op = 2'b10; data = 4'h1;
        tick(); check("sw_cap", bus.io_out, 8'h66);
        op = 2'b11;
        tick(); check("sw_exec", bus.io_out, 8'h66);
        tick(); check("sw_apply", bus.io_out, 8'h6D);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sw_hold_%0d", i), bus.io_out, 8'h6D);
        end
        op = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sw_rel_%0d", i), bus.io_out, 8'h6D);
        end

        // 8 + 9 = 0x11: digit 1 with overflow, then ADD 0 keeps both
        do_cmd(2'b01, 4'h8, r); check("ld8", r, 8'h7F);
        do_cmd(2'b10, 4'h9, r); check("add9_carry", r, 8'h86);
        do_cmd(2'b10, 4'h0, r); check("add0_digit", {1'b0, r[6:0]}, 8'h06);
        seen_hi = 1'b0; seen_lo = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.io_out[7]) seen_hi = 1'b1; else seen_lo = 1'b1;
        end
        check("add0_ovf_blinks", {6'b0, seen_hi, seen_lo}, 8'h03);
        check("add0_digit_kept", bus.io_out & 8'h7F, 8'h06);

        // LOAD every digit: segment table and ovf cleared by LOAD
        for (int d = 0; d < 16; d++) begin
            do_cmd(2'b01, 4'(d), r);
            check($sformatf("ld_digit_%0h", d), r, {1'b0, seg_ref[d]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
